dual_port_ram_p: RTL and testbench

DUAL_PORT_RAM_P -- requirements
Module: dual_port_ram_p

---
 rtl/dual_port_ram_p.sv | 196 +++++++++++++++++++
 tb/tb_dual_port_ram_p.sv | 235 +++++++++++++++++++++++
 2 files changed

// File: rtl/dual_port_ram_p.sv
// dual_port_ram_p
//   True dual-port RAM with a power-on clear sweep, selectable read latency
//   and same-address write collision arbitration.
//
//   Parameters
//     DATA_W  word width (both ports)
//     ADDR_W  address width, depth = 2**ADDR_W
//     RD_LAT  read latency, 1 or 2 (any value other than 2 behaves as 1)
//     PRIO_B  same-address write winner: 0 = port A, 1 = port B
//
//   Ports
//     clk, rst_n          clock, asynchronous active-low reset
//     ready               high once the clear sweep has finished
//     wea/web, rea/reb    write / read enables per port
//     addra/addrb         word addresses
//     dia/dib             write data
//     doa/dob             registered read data (held between reads)
//     vala/valb           one-cycle pulse qualifying doa/dob
//     err_a/err_b         one-cycle pulse: write and read requested together
//     coll                one-cycle pulse: both ports wrote one address
module dual_port_ram_p #(
    parameter int DATA_W = 8,
    parameter int ADDR_W = 8,
    parameter int RD_LAT = 1,
    parameter int PRIO_B = 0
) (
    input  logic              clk,
    input  logic              rst_n,
    output logic              ready,
    input  logic              wea,
    input  logic              web,
    input  logic              rea,
    input  logic              reb,
    input  logic [ADDR_W-1:0] addra,
    input  logic [ADDR_W-1:0] addrb,
    input  logic [DATA_W-1:0] dia,
    input  logic [DATA_W-1:0] dib,
    output logic [DATA_W-1:0] doa,
    output logic [DATA_W-1:0] dob,
    output logic              vala,
    output logic              valb,
    output logic              err_a,
    output logic              err_b,
    output logic              coll
);

    localparam int DEPTH  = 2 ** ADDR_W;
    localparam bit B_WINS = (PRIO_B != 0);

    typedef enum logic {ST_CLEAR, ST_RUN} state_t;

    state_t            state_reg;
    logic [ADDR_W-1:0] clr_ptr_reg;
    logic              ready_reg;
    logic              coll_reg;

    logic [DATA_W-1:0] mem [DEPTH];

    // Per-port views so both ports share one generate body.
    logic [1:0]        we;
    logic [1:0]        re;
    logic [ADDR_W-1:0] addr [2];
    logic [DATA_W-1:0] di   [2];
    logic [1:0]        wr_ok;
    logic [1:0]        rd_ok;
    logic [1:0]        bad;
    logic [1:0]        wr_en;
    logic              wr_same;
    logic              run;

    logic [DATA_W-1:0] dout [2];
    logic [1:0]        dval;
    logic [1:0]        derr;

    assign we      = {web, wea};
    assign re      = {reb, rea};
    assign addr[0] = addra;
    assign addr[1] = addrb;
    assign di[0]   = dia;
    assign di[1]   = dib;
    assign run     = (state_reg == ST_RUN);

    assign wr_same  = wr_ok[0] & wr_ok[1] & (addra == addrb);
    // On a same-address collision only the winning port's write is enabled.
    assign wr_en[0] = wr_ok[0] & ~(wr_same & B_WINS);
    assign wr_en[1] = wr_ok[1] & ~(wr_same & ~B_WINS);

    // Clear sweep FSM and collision flag.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg   <= ST_CLEAR;
            clr_ptr_reg <= '0;
            ready_reg   <= 1'b0;
            coll_reg    <= 1'b0;
        end else begin
            coll_reg <= wr_same;
            case (state_reg)
                ST_CLEAR: begin
                    clr_ptr_reg <= clr_ptr_reg + ADDR_W'(1);
                    if (&clr_ptr_reg) begin
                        state_reg <= ST_RUN;
                        ready_reg <= 1'b1;
                    end
                end
                default: begin
                    state_reg <= ST_RUN;
                end
            endcase
        end
    end

    // Storage array: no reset, so it maps onto block RAM. During the sweep the
    // array is owned by the clear pointer; port writes are gated by run.
    always_ff @(posedge clk) begin
        if (state_reg == ST_CLEAR) begin
            mem[clr_ptr_reg] <= '0;
        end else begin
            for (int p = 0; p < 2; p++) begin
                if (wr_en[p]) begin
                    mem[addr[p]] <= di[p];
                end
            end
        end
    end

    genvar gi;
    generate
        for (gi = 0; gi < 2; gi++) begin : g_port
            logic              s1_val_reg;
            logic              s1_err_reg;
            logic [DATA_W-1:0] s1_data_reg;

            assign wr_ok[gi] = run & we[gi] & ~re[gi];
            assign rd_ok[gi] = run & re[gi] & ~we[gi];
            assign bad[gi]   = run & we[gi] & re[gi];

            // First stage samples the array at the request edge; the array
            // write of the same edge lands afterwards, giving read-first.
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    s1_val_reg  <= 1'b0;
                    s1_err_reg  <= 1'b0;
                    s1_data_reg <= '0;
                end else begin
                    s1_val_reg <= rd_ok[gi];
                    s1_err_reg <= bad[gi];
                    if (rd_ok[gi]) begin
                        s1_data_reg <= mem[addr[gi]];
                    end else if (bad[gi]) begin
                        s1_data_reg <= '0;
                    end
                end
            end

            if (RD_LAT == 2) begin : g_lat2
                logic              s2_val_reg;
                logic              s2_err_reg;
                logic [DATA_W-1:0] s2_data_reg;

                always_ff @(posedge clk or negedge rst_n) begin
                    if (!rst_n) begin
                        s2_val_reg  <= 1'b0;
                        s2_err_reg  <= 1'b0;
                        s2_data_reg <= '0;
                    end else begin
                        s2_val_reg <= s1_val_reg;
                        s2_err_reg <= s1_err_reg;
                        if (s1_val_reg) begin
                            s2_data_reg <= s1_data_reg;
                        end else if (s1_err_reg) begin
                            s2_data_reg <= '0;
                        end
                    end
                end

                assign dout[gi] = s2_data_reg;
                assign dval[gi] = s2_val_reg;
                assign derr[gi] = s2_err_reg;
            end else begin : g_lat1
                assign dout[gi] = s1_data_reg;
                assign dval[gi] = s1_val_reg;
                assign derr[gi] = s1_err_reg;
            end
        end
    endgenerate

    assign ready = ready_reg;
    assign coll  = coll_reg;
    assign doa   = dout[0];
    assign dob   = dout[1];
    assign vala  = dval[0];
    assign valb  = dval[1];
    assign err_a = derr[0];
    assign err_b = derr[1];

endmodule

// File: tb/tb_dual_port_ram_p.sv
// Scoreboard bench for dual_port_ram_p. Two instances share the stimulus:
// dut0 = RD_LAT 1 / port A wins collisions, dut1 = RD_LAT 2 / port B wins.
// A behavioural model predicts each response and queues it with the edge
// after which it must be visible; a negedge monitor pops and compares.
module tb_dual_port_ram_p;
    localparam int DW  = 8;
    localparam int AW  = 4;
    localparam int DEP = 16;
    localparam int BIG = 32'h3fff_ffff;

    typedef struct {
        int         due;
        bit         is_err;
        logic [7:0] data;
    } exp_t;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic          rst_n;
    logic          wea, rea, web, reb;
    logic [AW-1:0] addra, addrb;
    logic [DW-1:0] dia, dib;

    logic          rdy  [2];
    logic [DW-1:0] dout [2][2];
    logic          val  [2][2];
    logic          err  [2][2];
    logic          coll [2];

    int   edge_cnt = 0;
    int   ready_edge = BIG;
    int   n_checks = 0;
    int   n_fail = 0;
    bit   mon_en = 1'b0;

    logic [7:0] mm [2][DEP];
    exp_t       q  [2][2][$];
    int         cq [2][$];
    logic [7:0] last_do [2][2];

    dual_port_ram_p #(.DATA_W(DW), .ADDR_W(AW), .RD_LAT(1), .PRIO_B(0)) dut0 (
        .clk(clk), .rst_n(rst_n), .ready(rdy[0]),
        .wea(wea), .web(web), .rea(rea), .reb(reb),
        .addra(addra), .addrb(addrb), .dia(dia), .dib(dib),
        .doa(dout[0][0]), .dob(dout[0][1]), .vala(val[0][0]), .valb(val[0][1]),
        .err_a(err[0][0]), .err_b(err[0][1]), .coll(coll[0])
    );

    dual_port_ram_p #(.DATA_W(DW), .ADDR_W(AW), .RD_LAT(2), .PRIO_B(1)) dut1 (
        .clk(clk), .rst_n(rst_n), .ready(rdy[1]),
        .wea(wea), .web(web), .rea(rea), .reb(reb),
        .addra(addra), .addrb(addrb), .dia(dia), .dib(dib),
        .doa(dout[1][0]), .dob(dout[1][1]), .vala(val[1][0]), .valb(val[1][1]),
        .err_a(err[1][0]), .err_b(err[1][1]), .coll(coll[1])
    );

    always @(posedge clk) edge_cnt <= edge_cnt + 1;

    task automatic chk(input string nm, input int d, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s dut%0d edge %0d: got %0h expected %0h", nm, d, edge_cnt, act, exp);
        end
    endtask

    // Reference model: applies one cycle of requests sampled at edge k+1.
    task automatic model(input int k, input bit wa, input bit ra, input logic [3:0] aa, input logic [7:0] da,
                         input bit wb, input bit rb, input logic [3:0] ab, input logic [7:0] db);
        bit         w [2];
        bit         r [2];
        logic [3:0] a [2];
        exp_t       e;
        w[0] = wa; w[1] = wb; r[0] = ra; r[1] = rb; a[0] = aa; a[1] = ab;
        for (int d = 0; d < 2; d++) begin
            if (k < ready_edge) continue;
            for (int p = 0; p < 2; p++) begin
                e.due = k + d + 1;   // read latency of dut d is d+1
                if (r[p] && !w[p]) begin
                    e.is_err = 1'b0; e.data = mm[d][a[p]]; q[d][p].push_back(e);
                end else if (r[p] && w[p]) begin
                    e.is_err = 1'b1; e.data = 8'h00; q[d][p].push_back(e);
                end
            end
            if (w[0] && !r[0] && w[1] && !r[1] && aa == ab) begin
                mm[d][aa] = (d == 1) ? db : da;
                cq[d].push_back(k + 1);
            end else begin
                if (w[0] && !r[0]) mm[d][aa] = da;
                if (w[1] && !r[1]) mm[d][ab] = db;
            end
        end
    endtask

    task automatic drive(input bit wa, input bit ra, input logic [3:0] aa, input logic [7:0] da,
                         input bit wb, input bit rb, input logic [3:0] ab, input logic [7:0] db);
        wea = wa; rea = ra; addra = aa; dia = da;
        web = wb; reb = rb; addrb = ab; dib = db;
        model(edge_cnt, wa, ra, aa, da, wb, rb, ab, db);
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) drive(0, 0, 4'd0, 8'd0, 0, 0, 4'd0, 8'd0);
    endtask

    task automatic model_reset();
        ready_edge = BIG;
        for (int d = 0; d < 2; d++) begin
            cq[d].delete();
            for (int p = 0; p < 2; p++) begin
                q[d][p].delete();
                last_do[d][p] = 8'h00;
            end
            for (int i = 0; i < DEP; i++) mm[d][i] = 8'h00;
        end
    endtask

    always @(negedge clk) begin
        bit ep, ec;
        if (mon_en) begin
            for (int d = 0; d < 2; d++) begin
                chk("ready", d, 32'(rdy[d]), 32'(edge_cnt >= ready_edge));
                for (int p = 0; p < 2; p++) begin
                    exp_t e;
                    ep = (q[d][p].size() > 0) && (q[d][p][0].due == edge_cnt);
                    e.is_err = 1'b0;
                    if (ep) begin
                        e = q[d][p].pop_front();
                        last_do[d][p] = e.data;
                    end
                    chk(p ? "valb" : "vala", d, 32'(val[d][p]), 32'(ep && !e.is_err));
                    chk(p ? "err_b" : "err_a", d, 32'(err[d][p]), 32'(ep && e.is_err));
                    chk(p ? "dob" : "doa", d, 32'(dout[d][p]), 32'(last_do[d][p]));
                end
                ec = (cq[d].size() > 0) && (cq[d][0] == edge_cnt);
                if (ec) void'(cq[d].pop_front());
                chk("coll", d, 32'(coll[d]), 32'(ec));
            end
        end
    end

    initial begin
        rst_n = 1'b0;
        wea = 0; rea = 0; web = 0; reb = 0;
        addra = '0; addrb = '0; dia = '0; dib = '0;
        model_reset();
        @(posedge clk);
        #1;
        mon_en = 1'b1;
        idle(2);

        // Release reset; random traffic during the sweep must be ignored.
        rst_n = 1'b1;
        ready_edge = edge_cnt + DEP;
        for (int i = 0; i < DEP; i++)
            drive(1, 0, 4'($urandom_range(0, 15)), 8'($urandom), 1, 0, 4'($urandom_range(0, 15)), 8'($urandom));
        idle(2);

        // Every word reads back zero after the sweep.
        for (int i = 0; i < DEP; i++) drive(0, 1, 4'(i), 8'd0, 0, 1, 4'(15 - i), 8'd0);
        idle(3);

        // Write on A, read on B the next cycle.
        drive(1, 0, 4'd3, 8'hA5, 0, 0, 4'd0, 8'd0);
        drive(0, 0, 4'd0, 8'd0, 0, 1, 4'd3, 8'd0);
        idle(3);

        // Preload 0..3, then back-to-back reads on A.
        for (int i = 0; i < 4; i++) drive(1, 0, 4'(i), 8'(8'h10 + i), 0, 0, 4'd0, 8'd0);
        for (int i = 0; i < 4; i++) drive(0, 1, 4'(i), 8'd0, 0, 0, 4'd0, 8'd0);
        idle(3);

        // Same-address collision, then read back the winner.
        drive(1, 0, 4'd5, 8'h11, 1, 0, 4'd5, 8'h22);
        drive(0, 1, 4'd5, 8'd0, 0, 1, 4'd5, 8'd0);
        // Different-address double write.
        drive(1, 0, 4'd6, 8'h66, 1, 0, 4'd8, 8'h88);
        drive(0, 1, 4'd6, 8'd0, 0, 1, 4'd8, 8'd0);
        idle(3);

        // Illegal request leaves memory intact and clears do.
        drive(1, 0, 4'd7, 8'h5A, 0, 0, 4'd0, 8'd0);
        drive(0, 1, 4'd7, 8'd0, 0, 0, 4'd0, 8'd0);
        drive(1, 1, 4'd7, 8'hFF, 0, 0, 4'd0, 8'd0);
        drive(0, 1, 4'd7, 8'd0, 0, 0, 4'd0, 8'd0);
        idle(3);

        // Cross-port read and write of one address: pre-write data returned.
        drive(1, 0, 4'd9, 8'h77, 0, 1, 4'd9, 8'd0);
        drive(0, 0, 4'd0, 8'd0, 0, 1, 4'd9, 8'd0);
        idle(3);

        // Randomized traffic over a small address range to provoke overlaps.
        for (int i = 0; i < 400; i++)
            drive($urandom_range(0, 2) == 0, $urandom_range(0, 1) == 0, 4'($urandom_range(0, 7)), 8'($urandom),
                  $urandom_range(0, 2) == 0, $urandom_range(0, 1) == 0, 4'($urandom_range(0, 7)), 8'($urandom));
        idle(3);

        // Reset one cycle after issuing a read: the read must vanish.
        drive(0, 1, 4'd7, 8'd0, 0, 1, 4'd3, 8'd0);
        rst_n = 1'b0;
        model_reset();
        #1;
        for (int d = 0; d < 2; d++) begin
            chk("rst_ready", d, 32'(rdy[d]), 32'd0);
            chk("rst_coll", d, 32'(coll[d]), 32'd0);
            for (int p = 0; p < 2; p++) begin
                chk("rst_do", d, 32'(dout[d][p]), 32'd0);
                chk("rst_val", d, 32'(val[d][p]), 32'd0);
                chk("rst_err", d, 32'(err[d][p]), 32'd0);
            end
        end
        @(posedge clk);
        #1;
        idle(3);
        rst_n = 1'b1;
        ready_edge = edge_cnt + DEP;
        idle(DEP + 2);
        // Contents written before reset are gone.
        drive(0, 1, 4'd7, 8'd0, 0, 1, 4'd3, 8'd0);
        drive(0, 1, 4'd5, 8'd0, 0, 1, 4'd9, 8'd0);
        idle(4);

        for (int d = 0; d < 2; d++) begin
            chk("pending_coll", d, 32'(cq[d].size()), 32'd0);
            for (int p = 0; p < 2; p++) chk("pending_rd", d, 32'(q[d][p].size()), 32'd0);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
